// File: rtl/hdr_frame_reader_pkg.sv
// hdr_frame_reader_pkg
//   Shared definitions for the frame-buffer read path: RGB565 pixel packing
//   inside a 128-bit RAM word, frame geometry, FSM state encodings and a
//   helper that extracts one pixel from a packed word.
//   The packing matches the tone mapper's write side: 8 pixels per word,
//   pixel k = word[16k+15:16k] = {R[4:0], G[5:0], B[4:0]}, pixel 0 first.
package hdr_frame_reader_pkg;

  localparam int PIX_W        = 16;
  localparam int R_W          = 5;
  localparam int G_W          = 6;
  localparam int B_W          = 5;
  localparam int PIX_PER_WORD = 8;
  localparam int RAM_DATA_W   = 128;
  localparam int FRAME_W      = 640;
  localparam int FRAME_H      = 480;

  localparam int PIX_IDX_W    = 3;
  localparam int PIX_CNT_W    = 19;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef struct packed {
    logic [R_W-1:0] red;
    logic [G_W-1:0] green;
    logic [B_W-1:0] blue;
  } rgb565_t;

  // Pixel idx sits at bit offset 16*idx; {idx,4'b0} is that offset.
  function automatic rgb565_t pixel_of(input logic [RAM_DATA_W-1:0] word,
                                       input logic [PIX_IDX_W-1:0]  idx);
    return rgb565_t'(word[{idx, 4'b0000} +: PIX_W]);
  endfunction

endpackage

// File: rtl/hdr_word_fifo.sv
// hdr_word_fifo
//   Small synchronous FIFO holding returned RAM words until the unpack
//   register can take them. DEPTH must be a power of two and >= 2.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   wr_en, wr_data  push a word (accepted when not full, or when popping)
//   rd_en           pop the head word (ignored when empty)
//   rd_data         head word, valid whenever empty is low
//   empty           no words stored
//   count           number of stored words, 0..DEPTH
module hdr_word_fifo #(
  parameter  int WIDTH = 128,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = rd_en && !empty;
  // A pop in the same cycle frees the slot, so a push at full still lands.
  assign do_push = wr_en && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/hdr_frame_reader.sv
// hdr_frame_reader
//   Read side of the tone-mapped frame buffer. Issues one read request per
//   128-bit word of a frame, buffers the returned words, and streams them
//   out one RGB565 pixel per handshake to the display path.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   frame_start              pulse: start a frame (only honoured in IDLE)
//   ram_busy                 RAM controller cannot take a request
//   rd_req, rd_addr          one-cycle read request and its word address
//   rd_valid, rd_data        returned words, in request order
//   pix_ready                downstream accepts the current pixel
//   pix_valid                pixel outputs valid
//   pix_red/green/blue       current pixel
//   pix_last                 current pixel is the last of the frame
//   frame_done               one-cycle pulse after the last pixel is taken
//   busy                     reader is not idle
module hdr_frame_reader
  import hdr_frame_reader_pkg::*;
#(
  parameter int WORDS_PER_FRAME = FRAME_W * FRAME_H / PIX_PER_WORD,
  parameter int BASE_ADDR       = 0,
  parameter int ADDR_W          = 22,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  ram_busy,
  output logic                  rd_req,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic                  rd_valid,
  input  logic [RAM_DATA_W-1:0] rd_data,
  input  logic                  pix_ready,
  output logic                  pix_valid,
  output logic [R_W-1:0]        pix_red,
  output logic [G_W-1:0]        pix_green,
  output logic [B_W-1:0]        pix_blue,
  output logic                  pix_last,
  output logic                  frame_done,
  output logic                  busy
);

  localparam int WCNT_W = $clog2(WORDS_PER_FRAME + 1);
  localparam int CRED_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [PIX_CNT_W-1:0] LAST_PIX = PIX_CNT_W'(WORDS_PER_FRAME * PIX_PER_WORD - 1);

  logic [1:0]              state;
  logic [WCNT_W-1:0]       word_cnt;
  logic [CRED_W-1:0]       outstanding;
  logic [CRED_W-1:0]       fifo_count;
  logic [CRED_W:0]         in_flight;
  logic                    fifo_empty;
  logic [RAM_DATA_W-1:0]   fifo_rdata;

  logic                    start_frame;
  logic                    issue;
  logic                    last_issue;
  logic                    rd_accept;
  logic                    pix_hs;
  logic                    word_done;
  logic                    load_word;
  logic                    frame_end;

  logic [RAM_DATA_W-1:0]   out_word;
  logic                    out_valid;
  logic [PIX_IDX_W-1:0]    pix_idx;
  logic [PIX_CNT_W-1:0]    pix_cnt;
  rgb565_t                 cur_pix;

  // A start pulse landing on the frame_done cycle is treated as stale.
  assign start_frame = (state == ST_IDLE) && frame_start && !frame_done;

  // Requests in flight plus words already buffered must fit in the FIFO,
  // so a returning word always has a slot. The unpack register is not
  // counted: once it loads, its FIFO slot is free for one more request.
  assign in_flight  = {1'b0, outstanding} + {1'b0, fifo_count};
  assign issue      = (state == ST_RUN) && !ram_busy && (in_flight < (CRED_W+1)'(FIFO_DEPTH));
  assign last_issue = issue && (word_cnt == WCNT_W'(WORDS_PER_FRAME - 1));

  // Words arriving with no request outstanding (e.g. after a reset that
  // aborted a frame) are stale and dropped.
  assign rd_accept  = rd_valid && (outstanding != '0);

  assign pix_hs     = out_valid && pix_ready;
  assign word_done  = pix_hs && (pix_idx == PIX_IDX_W'(PIX_PER_WORD - 1));
  assign load_word  = !fifo_empty && (!out_valid || word_done);
  assign frame_end  = (state == ST_DRAIN) && pix_hs && pix_last;

  assign cur_pix    = pixel_of(out_word, pix_idx);
  assign pix_valid  = out_valid;
  assign pix_red    = cur_pix.red;
  assign pix_green  = cur_pix.green;
  assign pix_blue   = cur_pix.blue;
  assign pix_last   = out_valid && (pix_cnt == LAST_PIX);
  assign busy       = (state != ST_IDLE);

  hdr_word_fifo #(
    .WIDTH (RAM_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (rd_accept),
    .wr_data (rd_data),
    .rd_en   (load_word),
    .rd_data (fifo_rdata),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (start_frame) state <= ST_RUN;
        ST_RUN:   if (last_issue)  state <= ST_DRAIN;
        ST_DRAIN: if (frame_end)   state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt <= '0;
      rd_req   <= 1'b0;
      rd_addr  <= '0;
    end else begin
      rd_req <= issue;
      if (start_frame) begin
        word_cnt <= '0;
      end else if (issue) begin
        word_cnt <= word_cnt + WCNT_W'(1);
      end
      if (issue) begin
        rd_addr <= ADDR_W'(BASE_ADDR) + ADDR_W'(word_cnt);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      case ({issue, rd_accept})
        2'b10:   outstanding <= outstanding + CRED_W'(1);
        2'b01:   outstanding <= outstanding - CRED_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Unpack register: reloads on the handshake of pixel 7 so consecutive
  // words stream without a bubble when the FIFO has data.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_word  <= '0;
      out_valid <= 1'b0;
      pix_idx   <= '0;
    end else if (load_word) begin
      out_word  <= fifo_rdata;
      out_valid <= 1'b1;
      pix_idx   <= '0;
    end else if (pix_hs) begin
      pix_idx <= pix_idx + PIX_IDX_W'(1);
      if (word_done) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (start_frame || frame_end) begin
        pix_cnt <= '0;
      end else if (pix_hs) begin
        pix_cnt <= pix_cnt + PIX_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hdr_frame_reader.sv
// tb_hdr_frame_reader
//   Directed bench for hdr_frame_reader with an 8-word frame at base 0x100
//   and a 4-deep FIFO. A behavioural RAM answers requests in order after a
//   configurable latency; word w of a frame carries pixel values seed+8w+k.
module tb_hdr_frame_reader;

  localparam int WORDS  = 8;
  localparam int BASE   = 32'h100;
  localparam int ADDR_W = 22;
  localparam int NPIX   = WORDS * 8;

  logic          clk;
  logic          rst;
  logic          frame_start;
  logic          ram_busy;
  logic          rd_req;
  logic [21:0]   rd_addr;
  logic          rd_valid;
  logic [127:0]  rd_data;
  logic          pix_ready;
  logic          pix_valid;
  logic [4:0]    pix_red;
  logic [5:0]    pix_green;
  logic [4:0]    pix_blue;
  logic          pix_last;
  logic          frame_done;
  logic          busy;

  int            checks;
  int            failures;
  int            cyc;
  int            req_idx;
  int            pix_seen;
  int            frames_done;
  bit            done_expected;
  int            first_req_cyc;
  int            first_pix_cyc;
  int            first_hs_cyc;
  int            last_hs_cyc;
  int            lat_min;
  int            lat_max;
  int            ready_mode;
  bit            poke_at_end;
  logic [15:0]   seed;
  int            rsp_addr[$];
  int            rsp_due[$];
  int            last_due;
  int            k_start;
  int            snap;
  logic [15:0]   held_pix;

  hdr_frame_reader #(
    .WORDS_PER_FRAME (WORDS),
    .BASE_ADDR       (BASE),
    .ADDR_W          (ADDR_W),
    .FIFO_DEPTH      (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .ram_busy    (ram_busy),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .pix_ready   (pix_ready),
    .pix_valid   (pix_valid),
    .pix_red     (pix_red),
    .pix_green   (pix_green),
    .pix_blue    (pix_blue),
    .pix_last    (pix_last),
    .frame_done  (frame_done),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [127:0] make_word(input int addr);
    logic [127:0] w;
    for (int k = 0; k < 8; k++) begin
      w[k*16 +: 16] = 16'(int'(seed) + (addr - BASE) * 8 + k);
    end
    return w;
  endfunction

  // One clock of bench activity at the falling edge: RAM responses,
  // downstream ready, and checks of whatever the DUT presents this cycle.
  task automatic stepCycle();
    int  a;
    int  due;
    bit  hs;
    @(negedge clk);
    cyc++;
    frame_start = 1'b0;

    rd_valid = 1'b0;
    rd_data  = {4{32'hDEAD_BEEF}};
    if (rsp_due.size() > 0 && rsp_due[0] <= cyc) begin
      a = rsp_addr.pop_front();
      void'(rsp_due.pop_front());
      rd_valid = 1'b1;
      rd_data  = make_word(a);
    end
    if (rd_req === 1'b1) begin
      due = cyc + int'($urandom_range(lat_max, lat_min));
      if (due < last_due) due = last_due;
      last_due = due;
      rsp_addr.push_back(int'(rd_addr));
      rsp_due.push_back(due);
    end

    case (ready_mode)
      0:       pix_ready = 1'b1;
      1:       pix_ready = 1'b0;
      default: pix_ready = 1'($urandom_range(1, 0));
    endcase

    checkOutput("frame_done", 32'(frame_done), 32'(done_expected));
    done_expected = 1'b0;
    if (frame_done === 1'b1) begin
      frames_done++;
      if (poke_at_end) frame_start = 1'b1;
    end

    if (rd_req === 1'b1) begin
      if (first_req_cyc < 0) first_req_cyc = cyc;
      checkOutput("rd_addr", 32'(rd_addr), 32'(BASE + req_idx));
      req_idx++;
    end

    if (pix_valid === 1'b1 && first_pix_cyc < 0) first_pix_cyc = cyc;
    hs = (pix_valid === 1'b1) && pix_ready && (rst === 1'b0);
    if (hs) begin
      checkOutput("pixel", 32'({pix_red, pix_green, pix_blue}), 32'(16'(seed + 16'(pix_seen))));
      checkOutput("pix_last", 32'(pix_last), 32'(pix_seen == NPIX - 1));
      if (pix_seen == 0) first_hs_cyc = cyc;
      if (pix_seen == NPIX - 1) begin
        done_expected = 1'b1;
        last_hs_cyc   = cyc;
        if (poke_at_end) frame_start = 1'b1;
      end
      pix_seen++;
    end
  endtask

  task automatic applyStimulus(input bit start, input bit busy_in);
    frame_start = start;
    ram_busy    = busy_in;
    stepCycle();
  endtask

  task automatic newFrame(input logic [15:0] s, input int lmin, input int lmax, input int rmode);
    seed          = s;
    lat_min       = lmin;
    lat_max       = lmax;
    ready_mode    = rmode;
    req_idx       = 0;
    pix_seen      = 0;
    done_expected = 1'b0;
    first_req_cyc = -1;
    first_pix_cyc = -1;
    first_hs_cyc  = -1;
    last_hs_cyc   = -1;
  endtask

  task automatic runFrame(input int budget);
    int start_frames;
    int n;
    start_frames = frames_done;
    n = 0;
    while (frames_done == start_frames && n < budget) begin
      stepCycle();
      n++;
    end
    checkOutput("frame_timeout", 32'(frames_done - start_frames), 32'd1);
    checkOutput("req_count", 32'(req_idx), 32'(WORDS));
    checkOutput("pix_count", 32'(pix_seen), 32'(NPIX));
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0; frames_done = 0; last_due = 0;
    poke_at_end = 1'b0;
    rst = 1'b1; frame_start = 1'b0; ram_busy = 1'b0; pix_ready = 1'b0;
    rd_valid = 1'b0; rd_data = '0;
    newFrame(16'h0000, 3, 3, 0);

    // Reset state
    stepCycle();
    stepCycle();
    checkOutput("rst_pix_valid", 32'(pix_valid), 32'd0);
    checkOutput("rst_rd_req", 32'(rd_req), 32'd0);
    checkOutput("rst_rd_addr", 32'(rd_addr), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_pixel", 32'({pix_red, pix_green, pix_blue}), 32'd0);
    checkOutput("rst_pix_last", 32'(pix_last), 32'd0);
    rst = 1'b0;
    stepCycle();

    // Basic frame: latency 3, always ready, pixels 0x0000..0x003F
    newFrame(16'h0000, 3, 3, 0);
    k_start = cyc;
    applyStimulus(1'b1, 1'b0);
    checkOutput("basic_busy", 32'(busy), 32'd1);
    runFrame(300);
    checkOutput("basic_req_lat", 32'(first_req_cyc - k_start), 32'd2);
    checkOutput("basic_pix_lat", 32'(first_pix_cyc - k_start), 32'd7);
    checkOutput("basic_no_bubble", 32'(last_hs_cyc - first_hs_cyc), 32'(NPIX - 1));
    stepCycle();
    checkOutput("basic_idle", 32'(busy), 32'd0);

    // RAM busy for 10 cycles after the start pulse
    newFrame(16'h1000, 2, 2, 0);
    k_start = cyc;
    applyStimulus(1'b1, 1'b1);
    repeat (9) applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
    runFrame(300);
    checkOutput("busy_first_req", 32'(first_req_cyc - k_start), 32'd11);
    stepCycle();

    // Downstream stalled: 4 FIFO words + 1 in the unpack register
    newFrame(16'h2000, 1, 1, 1);
    applyStimulus(1'b1, 1'b0);
    repeat (30) stepCycle();
    checkOutput("hold_req", 32'(req_idx), 32'd5);
    checkOutput("hold_valid", 32'(pix_valid), 32'd1);
    held_pix = {pix_red, pix_green, pix_blue};
    checkOutput("hold_pixel", 32'(held_pix), 32'h2000);
    repeat (5) stepCycle();
    checkOutput("hold_stable", 32'({pix_red, pix_green, pix_blue}), 32'h2000);
    checkOutput("hold_req_after", 32'(req_idx), 32'd5);
    ready_mode = 0;
    runFrame(300);
    stepCycle();

    // Random ready and random latency 1..8
    newFrame(16'h3000, 1, 8, 2);
    applyStimulus(1'b1, 1'b0);
    runFrame(3000);
    stepCycle();

    // Reset mid-frame with reads outstanding
    newFrame(16'h4000, 6, 6, 0);
    applyStimulus(1'b1, 1'b0);
    for (int n = 0; n < 40 && req_idx < 3; n++) stepCycle();
    checkOutput("abort_reqs", 32'(req_idx >= 3), 32'd1);
    rst = 1'b1;
    stepCycle();
    checkOutput("abort_pix_valid", 32'(pix_valid), 32'd0);
    checkOutput("abort_rd_req", 32'(rd_req), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_pixel", 32'({pix_red, pix_green, pix_blue}), 32'd0);
    stepCycle();
    rst = 1'b0;
    newFrame(16'h4000, 6, 6, 0);
    snap = frames_done;
    for (int n = 0; n < 20; n++) begin
      stepCycle();
      checkOutput("abort_late_valid", 32'(pix_valid), 32'd0);
    end
    for (int n = 0; n < 50 && rsp_due.size() > 0; n++) stepCycle();
    checkOutput("abort_no_done", 32'(frames_done - snap), 32'd0);
    checkOutput("abort_no_req", 32'(req_idx), 32'd0);
    newFrame(16'h5000, 2, 2, 0);
    applyStimulus(1'b1, 1'b0);
    runFrame(300);
    stepCycle();

    // Start pulses during RUN, on the last handshake and on frame_done
    newFrame(16'h6000, 2, 2, 0);
    poke_at_end = 1'b1;
    snap = frames_done;
    applyStimulus(1'b1, 1'b0);
    repeat (5) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    runFrame(300);
    poke_at_end = 1'b0;
    repeat (15) stepCycle();
    checkOutput("restart_busy", 32'(busy), 32'd0);
    checkOutput("restart_req", 32'(req_idx), 32'(WORDS));
    checkOutput("restart_frames", 32'(frames_done - snap), 32'd1);
    checkOutput("frames_total", 32'(frames_done), 32'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
